bulk_transfer: RTL and testbench
================================

BULK_TRANSFER -- requirements
Module: bulk_transfer

Interface
REQ-001 SHALL have parameter MAX_PKT, default 512, meaning max OUT payload bytes per packet.
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning cycles allowed waiting for host DATA/handshake.
REQ-003 SHALL have ports: clock  in  1  system clock; reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: blk_start_i  in  1  token-accepted pulse; blk_tok_in_i  in  1  1=IN token, 0=OUT token; blk_clear_i  in  1  reset both data toggles to DATA0.
REQ-005 SHALL have ports: blk_done_o  out  1  transaction-finished pulse; blk_error_o  out  1  timeout/overflow pulse.
REQ-006 SHALL have ports: hsk_recv_i  in  1; hsk_type_i  in  2; hsk_send_o  out  1; hsk_sent_i  in  1; hsk_type_o  out  2 (ACK=2'b00, NAK=2'b10).
REQ-007 SHALL have ports: usb_recv_i  in  1; usb_type_i  in  2; usb_send_o  out  1; usb_busy_i  in  1; usb_sent_i  in  1; usb_type_o  out  2 (DATA0=2'b00, DATA1=2'b10).
REQ-008 SHALL have ports: usb_tvalid_i/usb_tready_o/usb_tlast_i/usb_tdata_i[8]  host OUT bytes in; m_tvalid_o/m_tlast_o/m_tdata_o[8]  OUT bytes to sink; out_ready_i  in  1  sink can accept MAX_PKT bytes; out_drop_o  out  1  discard last packet.
REQ-009 SHALL have ports: s_tvalid_i/s_tready_o/s_tlast_i/s_tdata_i[8]  IN bytes from source; usb_tvalid_o/usb_tready_i/usb_tlast_o/usb_tdata_o[8]  IN bytes to encoder; in_avail_i  in  1  full packet (or ZLP) ready; in_ack_o  out  1  host ACKed IN packet.

Function
REQ-010 SHALL implement FSM states IDLE, RXDAT, TXHSK, TXDAT, RXHSK; one-hot or binary at implementer's choice.
REQ-011 IDLE: blk_start_i with blk_tok_in_i=0 -> RXDAT; with blk_tok_in_i=1 and in_avail_i=1 -> TXDAT; with blk_tok_in_i=1 and in_avail_i=0 -> TXHSK with NAK.
REQ-012 RXDAT: bytes pass combinationally usb_* -> m_*; usb_tready_o SHALL be 1 in RXDAT, 0 otherwise; m_tvalid_o gated to 0 outside RXDAT.
REQ-013 RXDAT: byte counter (width clog2(MAX_PKT+1)) increments per accepted byte; count exceeding MAX_PKT -> out_drop_o pulse, blk_error_o pulse, IDLE, no handshake.
REQ-014 RXDAT: on usb_recv_i, if out_ready_i=0 -> NAK + out_drop_o; else if usb_type_i equals OUT toggle -> ACK, toggle flips; else (repeat packet) -> ACK + out_drop_o, toggle unchanged; all go to TXHSK.
REQ-015 TXHSK: hsk_send_o SHALL assert one cycle after entry and hold with stable hsk_type_o until hsk_sent_i; then blk_done_o pulses one cycle and FSM returns to IDLE.
REQ-016 TXDAT: usb_send_o asserts with usb_type_o = IN toggle, held until usb_busy_i seen, then deasserted; s_* pass through to usb_* while in TXDAT; usb_sent_i -> RXHSK.
REQ-017 RXHSK: hsk_recv_i with ACK -> IN toggle flips, in_ack_o and blk_done_o pulse, IDLE; any other handshake or timeout -> toggle unchanged, blk_error_o pulse, IDLE (source retains packet for retry).
REQ-018 Timeout counter SHALL clear on every state change and on each accepted byte; reaching TIMEOUT in RXDAT or RXHSK -> blk_error_o pulse, IDLE; in RXDAT also out_drop_o.
REQ-019 blk_start_i outside IDLE SHALL be ignored.
REQ-020 blk_clear_i SHALL set both toggles to DATA0 in any state; coincident with an ACK flip, clear wins.
REQ-021 blk_done_o, blk_error_o, in_ack_o, out_drop_o SHALL be single-cycle registered pulses; done and error never coincide.

Reset
REQ-022 reset_n low SHALL asynchronously force IDLE, toggles DATA0, counters zero, all pulse/send outputs 0, hsk_type_o=ACK, usb_type_o=DATA0.
REQ-023 Deassertion of reset_n mid-transaction SHALL leave FSM in IDLE; partial packet not completed.

Verification
REQ-024 OUT token, out_ready_i=1, 4 bytes DATA0 -> m_* carries 4 bytes with tlast on 4th, ACK sent, OUT toggle=DATA1, blk_done_o one pulse.
REQ-025 Repeat OUT with DATA0 after toggle=DATA1 -> ACK sent, out_drop_o pulse, toggle stays DATA1.
REQ-026 IN token, in_avail_i=0 -> NAK sent, no usb_send_o, blk_done_o pulse.
REQ-027 IN token, in_avail_i=1, 8-byte packet, host ACK -> usb_type_o=DATA0, in_ack_o pulse, IN toggle=DATA1; repeat without ACK for TIMEOUT cycles -> blk_error_o, toggle stays DATA1.
REQ-028 OUT packet of MAX_PKT+1 bytes -> blk_error_o and out_drop_o pulse, no handshake, IDLE.
REQ-029 reset_n pulsed low during TXDAT -> usb_send_o=0 immediately, IDLE, toggles DATA0; blk_clear_i after toggles=DATA1 -> both DATA0.

Source files
------------

// File: rtl/bulk_transfer.sv
// USB bulk endpoint transaction engine: sequences OUT data reception and IN data
// transmission with DATA0/DATA1 toggle tracking, handshakes and timeouts.
module bulk_transfer #(
  parameter int MAX_PKT = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       blk_start_i,
  input  logic       blk_tok_in_i,
  input  logic       blk_clear_i,
  output logic       blk_done_o,
  output logic       blk_error_o,
  input  logic       hsk_recv_i,
  input  logic [1:0] hsk_type_i,
  output logic       hsk_send_o,
  input  logic       hsk_sent_i,
  output logic [1:0] hsk_type_o,
  input  logic       usb_recv_i,
  input  logic [1:0] usb_type_i,
  output logic       usb_send_o,
  input  logic       usb_busy_i,
  input  logic       usb_sent_i,
  output logic [1:0] usb_type_o,
  input  logic       usb_tvalid_i,
  output logic       usb_tready_o,
  input  logic       usb_tlast_i,
  input  logic [7:0] usb_tdata_i,
  output logic       m_tvalid_o,
  output logic       m_tlast_o,
  output logic [7:0] m_tdata_o,
  input  logic       out_ready_i,
  output logic       out_drop_o,
  input  logic       s_tvalid_i,
  output logic       s_tready_o,
  input  logic       s_tlast_i,
  input  logic [7:0] s_tdata_i,
  output logic       usb_tvalid_o,
  input  logic       usb_tready_i,
  output logic       usb_tlast_o,
  output logic [7:0] usb_tdata_o,
  input  logic       in_avail_i,
  output logic       in_ack_o
);

  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ACK = 2'b00;
  localparam logic [1:0] NAK = 2'b10;

  typedef enum logic [2:0] {IDLE, RXDAT, TXHSK, TXDAT, RXHSK} state_t;

  state_t        state, state_d;
  logic          tog_out, tog_out_d, tog_in, tog_in_d;
  logic [CW-1:0] byte_cnt, byte_cnt_d;
  logic [TW-1:0] tmo, tmo_d;
  logic          hsk_send_d, usb_send_d;
  logic [1:0]    hsk_type_d, usb_type_d;
  logic          done_d, error_d, in_ack_d, drop_d;
  logic          rxdat, txdat, byte_acc, tmo_hit;

  assign rxdat    = (state == RXDAT);
  assign txdat    = (state == TXDAT);
  assign byte_acc = rxdat & usb_tvalid_i;
  assign tmo_hit  = (tmo == TW'(TIMEOUT - 1));

  // Data paths are pure wires, gated by the owning state.
  assign usb_tready_o = rxdat;
  assign m_tvalid_o   = usb_tvalid_i & rxdat;
  assign m_tlast_o    = usb_tlast_i;
  assign m_tdata_o    = usb_tdata_i;
  assign s_tready_o   = usb_tready_i & txdat;
  assign usb_tvalid_o = s_tvalid_i & txdat;
  assign usb_tlast_o  = s_tlast_i;
  assign usb_tdata_o  = s_tdata_i;

  always_comb begin
    state_d    = state;
    tog_out_d  = tog_out;
    tog_in_d   = tog_in;
    byte_cnt_d = byte_cnt;
    tmo_d      = '0;
    hsk_send_d = hsk_send_o;
    hsk_type_d = hsk_type_o;
    usb_send_d = usb_send_o;
    usb_type_d = usb_type_o;
    done_d     = 1'b0;
    error_d    = 1'b0;
    in_ack_d   = 1'b0;
    drop_d     = 1'b0;
    case (state)
      IDLE: begin
        byte_cnt_d = '0;
        if (blk_start_i) begin
          if (!blk_tok_in_i) begin
            state_d = RXDAT;
          end else if (in_avail_i) begin
            state_d    = TXDAT;
            usb_send_d = 1'b1;
            usb_type_d = {tog_in, 1'b0};
          end else begin
            state_d    = TXHSK;
            hsk_type_d = NAK;
          end
        end
      end
      RXDAT: begin
        tmo_d = tmo + 1'b1;
        if (byte_acc) begin
          tmo_d      = '0;
          byte_cnt_d = byte_cnt + 1'b1;
        end
        if (byte_acc && byte_cnt == CW'(MAX_PKT)) begin
          state_d = IDLE;
          error_d = 1'b1;
          drop_d  = 1'b1;
        end else if (usb_recv_i) begin
          state_d    = TXHSK;
          hsk_type_d = ACK;
          if (!out_ready_i) begin
            hsk_type_d = NAK;
            drop_d     = 1'b1;
          end else if (usb_type_i == {tog_out, 1'b0}) begin
            tog_out_d = ~tog_out;
          end else begin
            drop_d = 1'b1;  // host retried a packet we already accepted
          end
        end else if (!byte_acc && tmo_hit) begin
          state_d = IDLE;
          error_d = 1'b1;
          drop_d  = 1'b1;
        end
      end
      TXHSK: begin
        if (hsk_send_o && hsk_sent_i) begin
          hsk_send_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          hsk_send_d = 1'b1;
        end
      end
      TXDAT: begin
        if (usb_busy_i) usb_send_d = 1'b0;
        if (usb_sent_i) begin
          usb_send_d = 1'b0;
          state_d    = RXHSK;
        end
      end
      RXHSK: begin
        tmo_d = tmo + 1'b1;
        if (hsk_recv_i) begin
          state_d = IDLE;
          if (hsk_type_i == ACK) begin
            tog_in_d = ~tog_in;
            in_ack_d = 1'b1;
            done_d   = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (blk_clear_i) begin
      tog_out_d = 1'b0;
      tog_in_d  = 1'b0;
    end
    if (state_d != state) tmo_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tog_out     <= 1'b0;
      tog_in      <= 1'b0;
      byte_cnt    <= '0;
      tmo         <= '0;
      hsk_send_o  <= 1'b0;
      hsk_type_o  <= ACK;
      usb_send_o  <= 1'b0;
      usb_type_o  <= 2'b00;
      blk_done_o  <= 1'b0;
      blk_error_o <= 1'b0;
      in_ack_o    <= 1'b0;
      out_drop_o  <= 1'b0;
    end else begin
      state       <= state_d;
      tog_out     <= tog_out_d;
      tog_in      <= tog_in_d;
      byte_cnt    <= byte_cnt_d;
      tmo         <= tmo_d;
      hsk_send_o  <= hsk_send_d;
      hsk_type_o  <= hsk_type_d;
      usb_send_o  <= usb_send_d;
      usb_type_o  <= usb_type_d;
      blk_done_o  <= done_d;
      blk_error_o <= error_d;
      in_ack_o    <= in_ack_d;
      out_drop_o  <= drop_d;
    end
  end

endmodule

// File: tb/tb_bulk_transfer.sv
// Randomized bench for bulk_transfer: plays host, source and sink, and predicts
// handshakes, drops and toggles from a transaction-level model.
module tb_bulk_transfer;
  localparam int MP = 16;
  localparam int TO = 32;

  logic clock, reset_n;
  logic blk_start_i, blk_tok_in_i, blk_clear_i, blk_done_o, blk_error_o;
  logic hsk_recv_i, hsk_send_o, hsk_sent_i;
  logic [1:0] hsk_type_i, hsk_type_o;
  logic usb_recv_i, usb_send_o, usb_busy_i, usb_sent_i;
  logic [1:0] usb_type_i, usb_type_o;
  logic usb_tvalid_i, usb_tready_o, usb_tlast_i;
  logic [7:0] usb_tdata_i;
  logic m_tvalid_o, m_tlast_o, out_ready_i, out_drop_o;
  logic [7:0] m_tdata_o;
  logic s_tvalid_i, s_tready_o, s_tlast_i;
  logic [7:0] s_tdata_i;
  logic usb_tvalid_o, usb_tready_i, usb_tlast_o, in_avail_i, in_ack_o;
  logic [7:0] usb_tdata_o;

  bulk_transfer #(.MAX_PKT(MP), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .blk_start_i(blk_start_i), .blk_tok_in_i(blk_tok_in_i), .blk_clear_i(blk_clear_i),
    .blk_done_o(blk_done_o), .blk_error_o(blk_error_o),
    .hsk_recv_i(hsk_recv_i), .hsk_type_i(hsk_type_i), .hsk_send_o(hsk_send_o),
    .hsk_sent_i(hsk_sent_i), .hsk_type_o(hsk_type_o),
    .usb_recv_i(usb_recv_i), .usb_type_i(usb_type_i), .usb_send_o(usb_send_o),
    .usb_busy_i(usb_busy_i), .usb_sent_i(usb_sent_i), .usb_type_o(usb_type_o),
    .usb_tvalid_i(usb_tvalid_i), .usb_tready_o(usb_tready_o), .usb_tlast_i(usb_tlast_i),
    .usb_tdata_i(usb_tdata_i), .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o),
    .m_tdata_o(m_tdata_o), .out_ready_i(out_ready_i), .out_drop_o(out_drop_o),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i),
    .s_tdata_i(s_tdata_i), .usb_tvalid_o(usb_tvalid_o), .usb_tready_i(usb_tready_i),
    .usb_tlast_o(usb_tlast_o), .usb_tdata_o(usb_tdata_o), .in_avail_i(in_avail_i),
    .in_ack_o(in_ack_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Event monitor: pulse counts and sink-side bytes, sampled mid-cycle.
  int n_done = 0, n_err = 0, n_drop = 0, n_inack = 0, n_hsk = 0, n_usend = 0, n_coinc = 0;
  logic hsk_prev = 1'b0;
  logic [8:0] rx_q[$];
  always @(negedge clock) begin
    if (blk_done_o === 1'b1) n_done <= n_done + 1;
    if (blk_error_o === 1'b1) n_err <= n_err + 1;
    if (out_drop_o === 1'b1) n_drop <= n_drop + 1;
    if (in_ack_o === 1'b1) n_inack <= n_inack + 1;
    if (usb_send_o === 1'b1) n_usend <= n_usend + 1;
    if (blk_done_o === 1'b1 && blk_error_o === 1'b1) n_coinc <= n_coinc + 1;
    if (hsk_send_o === 1'b1 && hsk_prev !== 1'b1) n_hsk <= n_hsk + 1;
    hsk_prev <= hsk_send_o;
    if (m_tvalid_o === 1'b1) rx_q.push_back({m_tlast_o, m_tdata_o});
  end

  int n_checks = 0, n_fails = 0;
  bit m_tog_out = 1'b0, m_tog_in = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_hsk(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (hsk_send_o === 1'b1) begin ok = 1'b1; return; end
      tick(1);
    end
  endtask

  // Host OUT transaction: len bytes tagged DATA<dt>, sink readiness rdy.
  task automatic do_out(input int len, input bit dt, input bit rdy);
    int d0, e0, p0, base, bad;
    bit ok, exp_drop;
    logic [7:0] b;
    logic [8:0] exp_b[$];
    exp_drop = !rdy || (dt != m_tog_out);
    d0 = n_done; e0 = n_err; p0 = n_drop; base = rx_q.size(); bad = 0;
    blk_start_i = 1'b1; blk_tok_in_i = 1'b0; out_ready_i = rdy;
    tick(1);
    blk_start_i = 1'b0;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      usb_tvalid_i = 1'b1; usb_tdata_i = b; usb_tlast_i = (i == len - 1);
      exp_b.push_back({usb_tlast_i, b});
      tick(1);
    end
    usb_tvalid_i = 1'b0; usb_tlast_i = 1'b0;
    usb_recv_i = 1'b1; usb_type_i = {dt, 1'b0};
    tick(1);
    usb_recv_i = 1'b0;
    wait_hsk(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fails++; $display("FAIL out_hsk_send: no handshake within bound"); end
    n_checks++;
    if (hsk_type_o !== (rdy ? 2'b00 : 2'b10)) begin
      n_fails++; $display("FAIL out_hsk_type: got %b want %b", hsk_type_o, rdy ? 2'b00 : 2'b10);
    end
    hsk_sent_i = 1'b1;
    tick(1);
    hsk_sent_i = 1'b0;
    tick(2);
    n_checks++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
      n_fails++; $display("FAIL out_done: done %0d err %0d want 1 0", n_done - d0, n_err - e0);
    end
    n_checks++;
    if (n_drop - p0 !== int'(exp_drop)) begin
      n_fails++; $display("FAIL out_drop: got %0d want %0d", n_drop - p0, exp_drop);
    end
    n_checks++;
    if (rx_q.size() - base !== len) begin
      n_fails++; $display("FAIL out_bytes_count: got %0d want %0d", rx_q.size() - base, len);
    end else begin
      for (int i = 0; i < len; i++) if (rx_q[base + i] !== exp_b[i]) bad++;
      n_checks++;
      if (bad !== 0) begin n_fails++; $display("FAIL out_bytes_data: got %0d bad want 0", bad); end
    end
    if (rdy && !exp_drop) m_tog_out = ~m_tog_out;
  endtask

  // Host IN transaction; resp 0=ACK 1=NAK 2=silence. clr asserts clear with the reply.
  task automatic do_in(input bit avail, input int len, input int resp, input bit clr);
    int d0, e0, a0, h0, u0, bad;
    bit ok;
    logic [7:0] b;
    d0 = n_done; e0 = n_err; a0 = n_inack; h0 = n_hsk; u0 = n_usend; bad = 0;
    blk_start_i = 1'b1; blk_tok_in_i = 1'b1; in_avail_i = avail;
    tick(1);
    blk_start_i = 1'b0;
    if (!avail) begin
      wait_hsk(ok);
      n_checks++;
      if (ok !== 1'b1 || hsk_type_o !== 2'b10) begin
        n_fails++; $display("FAIL in_nak: send %b type %b want 1 10", ok, hsk_type_o);
      end
      hsk_sent_i = 1'b1;
      tick(1);
      hsk_sent_i = 1'b0;
      tick(2);
      n_checks++;
      if (n_done - d0 !== 1 || n_usend - u0 !== 0) begin
        n_fails++; $display("FAIL in_nak_done: done %0d usb_send %0d want 1 0", n_done - d0, n_usend - u0);
      end
      return;
    end
    n_checks++;
    if (usb_send_o !== 1'b1 || usb_type_o !== {m_tog_in, 1'b0}) begin
      n_fails++; $display("FAIL in_send: send %b type %b want 1 %b", usb_send_o, usb_type_o, {m_tog_in, 1'b0});
    end
    // encoder goes busy; a stray OUT start here must be ignored
    usb_busy_i = 1'b1; blk_start_i = 1'b1; blk_tok_in_i = 1'b0;
    tick(1);
    blk_start_i = 1'b0;
    n_checks++;
    if (usb_send_o !== 1'b0) begin n_fails++; $display("FAIL in_send_drop: got %b want 0", usb_send_o); end
    usb_tready_i = 1'b1;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      s_tvalid_i = 1'b1; s_tdata_i = b; s_tlast_i = (i == len - 1);
      @(negedge clock);
      if (usb_tvalid_o !== 1'b1 || usb_tdata_o !== b || usb_tlast_o !== (i == len - 1) ||
          s_tready_o !== 1'b1) bad++;
      tick(1);
    end
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0; usb_tready_i = 1'b0; usb_busy_i = 1'b0;
    n_checks++;
    if (bad !== 0) begin n_fails++; $display("FAIL in_passthru: got %0d bad want 0", bad); end
    usb_sent_i = 1'b1;
    tick(1);
    usb_sent_i = 1'b0;
    if (resp == 2) begin
      tick(TO - 3);
      n_checks++;
      if (n_err - e0 !== 0) begin n_fails++; $display("FAIL in_tmo_early: err %0d want 0", n_err - e0); end
      tick(8);
    end else begin
      tick(2);
      hsk_recv_i = 1'b1; hsk_type_i = (resp == 0) ? 2'b00 : 2'b10; blk_clear_i = clr;
      tick(1);
      hsk_recv_i = 1'b0; blk_clear_i = 1'b0;
      tick(2);
    end
    n_checks++;
    if (resp == 0) begin
      if (n_inack - a0 !== 1 || n_done - d0 !== 1 || n_err - e0 !== 0) begin
        n_fails++; $display("FAIL in_ack: ack %0d done %0d err %0d want 1 1 0", n_inack - a0, n_done - d0, n_err - e0);
      end
      m_tog_in = ~m_tog_in;
    end else if (n_inack - a0 !== 0 || n_done - d0 !== 0 || n_err - e0 !== 1) begin
      n_fails++; $display("FAIL in_err: ack %0d done %0d err %0d want 0 0 1", n_inack - a0, n_done - d0, n_err - e0);
    end
    n_checks++;
    if (n_hsk - h0 !== 0) begin n_fails++; $display("FAIL in_no_hsk: got %0d want 0", n_hsk - h0); end
    if (clr) begin m_tog_in = 1'b0; m_tog_out = 1'b0; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    usb_tvalid_i = 1'b1;
    tick(3);
    n_checks++;
    if ({hsk_send_o, usb_send_o, hsk_type_o, usb_type_o, blk_done_o, blk_error_o, in_ack_o, out_drop_o} !== 10'b0) begin
      n_fails++; $display("FAIL reset_outputs: got %b want 0", {hsk_send_o, usb_send_o, hsk_type_o, usb_type_o,
                          blk_done_o, blk_error_o, in_ack_o, out_drop_o});
    end
    n_checks++;
    if (usb_tready_o !== 1'b0 || m_tvalid_o !== 1'b0 || usb_tvalid_o !== 1'b0) begin
      n_fails++; $display("FAIL reset_gating: tready %b mvalid %b uvalid %b want 0", usb_tready_o, m_tvalid_o, usb_tvalid_o);
    end
    usb_tvalid_i = 1'b0;
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_out_basic;  do_out(4, 1'b0, 1'b1); endtask
  task automatic test_out_repeat; do_out(4, 1'b0, 1'b1); endtask
  task automatic test_out_not_ready; do_out(3, m_tog_out, 1'b0); endtask
  task automatic test_in_nak;     do_in(1'b0, 0, 0, 1'b0); endtask
  task automatic test_in_ack;     do_in(1'b1, 8, 0, 1'b0); endtask
  task automatic test_in_timeout; do_in(1'b1, 8, 2, 1'b0); endtask

  task automatic test_out_overflow;
    int e0, p0, h0, d0;
    e0 = n_err; p0 = n_drop; h0 = n_hsk; d0 = n_done;
    blk_start_i = 1'b1; blk_tok_in_i = 1'b0; out_ready_i = 1'b1;
    tick(1);
    blk_start_i = 1'b0;
    for (int i = 0; i <= MP; i++) begin
      usb_tvalid_i = 1'b1; usb_tdata_i = 8'(i); usb_tlast_i = (i == MP);
      tick(1);
    end
    usb_tvalid_i = 1'b0; usb_tlast_i = 1'b0;
    n_checks++;
    if (usb_tready_o !== 1'b0) begin n_fails++; $display("FAIL ovf_idle: tready %b want 0", usb_tready_o); end
    tick(3);
    n_checks++;
    if (n_err - e0 !== 1 || n_drop - p0 !== 1 || n_hsk - h0 !== 0 || n_done - d0 !== 0) begin
      n_fails++; $display("FAIL ovf: err %0d drop %0d hsk %0d done %0d want 1 1 0 0",
                          n_err - e0, n_drop - p0, n_hsk - h0, n_done - d0);
    end
  endtask

  task automatic test_out_timeout;
    int e0, p0;
    e0 = n_err; p0 = n_drop;
    blk_start_i = 1'b1; blk_tok_in_i = 1'b0; out_ready_i = 1'b1;
    tick(1);
    blk_start_i = 1'b0;
    tick(TO - 2);
    n_checks++;
    if (n_err - e0 !== 0) begin n_fails++; $display("FAIL out_tmo_early: err %0d want 0", n_err - e0); end
    tick(8);
    n_checks++;
    if (n_err - e0 !== 1 || n_drop - p0 !== 1) begin
      n_fails++; $display("FAIL out_tmo: err %0d drop %0d want 1 1", n_err - e0, n_drop - p0);
    end
  endtask

  task automatic test_reset_mid_txdat;
    int d0;
    d0 = n_done;
    blk_start_i = 1'b1; blk_tok_in_i = 1'b1; in_avail_i = 1'b1;
    tick(1);
    blk_start_i = 1'b0;
    n_checks++;
    if (usb_send_o !== 1'b1 || usb_type_o !== {m_tog_in, 1'b0}) begin
      n_fails++; $display("FAIL pre_reset_send: send %b type %b want 1 %b", usb_send_o, usb_type_o, {m_tog_in, 1'b0});
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (usb_send_o !== 1'b0) begin n_fails++; $display("FAIL async_reset: send %b want 0", usb_send_o); end
    tick(2);
    reset_n = 1'b1;
    m_tog_in = 1'b0; m_tog_out = 1'b0;
    tick(3);
    n_checks++;
    if (n_done - d0 !== 0 || usb_send_o !== 1'b0) begin
      n_fails++; $display("FAIL reset_idle: done %0d send %b want 0 0", n_done - d0, usb_send_o);
    end
    do_in(1'b1, 4, 0, 1'b0);
  endtask

  task automatic test_clear;
    do_out(4, m_tog_out, 1'b1);
    do_in(1'b1, 3, 0, 1'b0);
    blk_clear_i = 1'b1;
    tick(1);
    blk_clear_i = 1'b0;
    m_tog_in = 1'b0; m_tog_out = 1'b0;
    do_in(1'b1, 2, 0, 1'b0);
    do_out(3, 1'b0, 1'b1);
    do_in(1'b1, 2, 0, 1'b1);  // clear on the same cycle as an ACK flip
    do_in(1'b1, 2, 0, 1'b0);
    do_out(2, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0)
        do_out(int'($urandom_range(1, MP)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      else
        do_in(1'($urandom_range(0, 3) != 0), int'($urandom_range(1, 8)), int'($urandom_range(0, 1)), 1'b0);
      tick(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset_n = 1'b0; blk_start_i = 1'b0; blk_tok_in_i = 1'b0; blk_clear_i = 1'b0;
    hsk_recv_i = 1'b0; hsk_type_i = 2'b00; hsk_sent_i = 1'b0;
    usb_recv_i = 1'b0; usb_type_i = 2'b00; usb_busy_i = 1'b0; usb_sent_i = 1'b0;
    usb_tvalid_i = 1'b0; usb_tlast_i = 1'b0; usb_tdata_i = 8'h00; out_ready_i = 1'b1;
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tdata_i = 8'h00; usb_tready_i = 1'b0; in_avail_i = 1'b0;
    test_reset();
    test_out_basic();
    test_out_repeat();
    test_out_not_ready();
    test_in_nak();
    test_in_ack();
    test_in_timeout();
    test_out_overflow();
    test_out_timeout();
    test_reset_mid_txdat();
    test_clear();
    test_random();
    n_checks++;
    if (n_coinc !== 0) begin n_fails++; $display("FAIL done_error_overlap: got %0d want 0", n_coinc); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
